// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer: builds sign/num1/operator/num2 from key events and
// runs the start/done handshake with the ALU, with a timeout into ERR.
module calc_entry_ctrl #(
    parameter int NDIG = 3,
    parameter int TMO  = 255
) (
    input  logic                clk1kHz,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [4:0]          key_code,
    input  logic                alu_done,
    input  logic                alu_err,
    output logic [4*NDIG-1:0]   num1_bcd,
    output logic [2:0]          num1_len,
    output logic                num1_neg,
    output logic [1:0]          op_code,
    output logic                op_valid,
    output logic [4*NDIG-1:0]   num2_bcd,
    output logic [2:0]          num2_len,
    output logic                alu_start,
    output logic [2:0]          state,
    output logic                err
);

    typedef enum logic [2:0] {
        S_SIGN = 3'd0,
        S_NUM1 = 3'd1,
        S_NUM2 = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [4:0] K_ADD  = 5'd10;
    localparam logic [4:0] K_SUB  = 5'd11;
    localparam logic [4:0] K_DIV  = 5'd13;
    localparam logic [4:0] K_EQ   = 5'd14;
    localparam logic [4:0] K_CLR  = 5'd15;
    localparam logic [4:0] K_BKSP = 5'd16;

    localparam int          TW      = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [2:0]  LEN_MAX = 3'(NDIG);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    state_t          state_q;
    logic [TW-1:0]   timer;

    logic       is_digit;
    logic       is_op;
    logic [3:0] digit;

    assign is_digit = key_code < 5'd10;
    assign is_op    = (key_code >= K_ADD) && (key_code <= K_DIV);
    assign digit    = key_code[3:0];
    assign state    = state_q;

    function automatic logic [4*NDIG-1:0] bcd_push(input logic [4*NDIG-1:0] bcd,
                                                   input logic [3:0] d);
        logic [4*NDIG-1:0] r;
        r      = bcd << 4;
        r[3:0] = d;
        return r;
    endfunction

    // NOTE: every register here is written with <= so all updates in a cycle
    // see the pre-edge values; mixing in = would make results order-dependent.
    always_ff @(posedge clk1kHz) begin
        if (rst || (key_valid && key_code == K_CLR)) begin
            state_q   <= S_SIGN;
            num1_bcd  <= '0;
            num1_len  <= '0;
            num1_neg  <= 1'b0;
            op_code   <= '0;
            op_valid  <= 1'b0;
            num2_bcd  <= '0;
            num2_len  <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            timer     <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state_q)
                S_SIGN: if (key_valid) begin
                    if (is_digit) begin
                        num1_bcd <= bcd_push(num1_bcd, digit);
                        num1_len <= num1_len + 3'd1;
                        state_q  <= S_NUM1;
                    end else if (key_code == K_SUB) begin
                        num1_neg <= 1'b1;
                        state_q  <= S_NUM1;
                    end
                end

                S_NUM1: if (key_valid) begin
                    if (is_digit) begin
                        if (num1_len < LEN_MAX) begin
                            num1_bcd <= bcd_push(num1_bcd, digit);
                            num1_len <= num1_len + 3'd1;
                        end
                    end else if (is_op) begin
                        if (num1_len != 3'd0) begin
                            op_code  <= 2'(key_code - K_ADD);
                            op_valid <= 1'b1;
                            state_q  <= S_NUM2;
                        end
                    end else if (key_code == K_BKSP) begin
                        if (num1_len != 3'd0) begin
                            num1_bcd <= num1_bcd >> 4;
                            num1_len <= num1_len - 3'd1;
                        end else begin
                            num1_neg <= 1'b0;
                            state_q  <= S_SIGN;
                        end
                    end
                end

                S_NUM2: if (key_valid) begin
                    if (is_digit) begin
                        if (num2_len < LEN_MAX) begin
                            num2_bcd <= bcd_push(num2_bcd, digit);
                            num2_len <= num2_len + 3'd1;
                        end
                    end else if (key_code == K_EQ) begin
                        if (num2_len != 3'd0) begin
                            alu_start <= 1'b1;
                            timer     <= '0;
                            state_q   <= S_EXEC;
                        end
                    end else if (key_code == K_BKSP) begin
                        if (num2_len != 3'd0) begin
                            num2_bcd <= num2_bcd >> 4;
                            num2_len <= num2_len - 3'd1;
                        end else begin
                            op_valid <= 1'b0;
                            op_code  <= '0;
                            state_q  <= S_NUM1;
                        end
                    end
                end

                // A result arriving on the last timer cycle still counts as done.
                S_EXEC: begin
                    if (alu_done) begin
                        err     <= alu_err;
                        state_q <= alu_err ? S_ERR : S_DONE;
                    end else if (timer == T_LAST) begin
                        err     <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_DONE: if (key_valid && (is_digit || key_code == K_SUB)) begin
                    num1_bcd <= '0;
                    num1_len <= '0;
                    num1_neg <= 1'b0;
                    op_code  <= '0;
                    op_valid <= 1'b0;
                    num2_bcd <= '0;
                    num2_len <= '0;
                    state_q  <= S_NUM1;
                    if (is_digit) begin
                        num1_bcd <= bcd_push('0, digit);
                        num1_len <= 3'd1;
                    end else begin
                        num1_neg <= 1'b1;
                    end
                end

                S_ERR: ;

                default: state_q <= S_SIGN;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: entry, execution, backspace, timeout,
// clear/done races and DONE restart, with hand-computed expectations.
module tb_calc_entry_ctrl;

    localparam int NDIG = 3;
    localparam int TMO  = 255;

    logic              clk1kHz = 1'b0;
    logic              rst = 1'b1;
    logic              key_valid = 1'b0;
    logic [4:0]        key_code = '0;
    logic              alu_done = 1'b0;
    logic              alu_err = 1'b0;
    logic [4*NDIG-1:0] num1_bcd, num2_bcd;
    logic [2:0]        num1_len, num2_len, state;
    logic              num1_neg, op_valid, alu_start, err;
    logic [1:0]        op_code;

    int vectors = 0;
    int miscompares = 0;

    calc_entry_ctrl #(.NDIG(NDIG), .TMO(TMO)) dut (
        .clk1kHz(clk1kHz), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_done(alu_done), .alu_err(alu_err),
        .num1_bcd(num1_bcd), .num1_len(num1_len), .num1_neg(num1_neg),
        .op_code(op_code), .op_valid(op_valid),
        .num2_bcd(num2_bcd), .num2_len(num2_len),
        .alu_start(alu_start), .state(state), .err(err)
    );

    always #5 clk1kHz = ~clk1kHz;

    logic [38:0] outs;
    assign outs = {num1_bcd, num1_len, num1_neg, op_code, op_valid,
                   num2_bcd, num2_len, alu_start, state, err};

    // Called at a negedge; returns at the next negedge with the key's effect visible.
    task automatic press(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk1kHz);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic pulse_done(input logic e);
        alu_done = 1'b1;
        alu_err  = e;
        @(negedge clk1kHz);
        alu_done = 1'b0;
        alu_err  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk1kHz);
        rst = 1'b0;
        if (outs !== 39'd0) begin
            miscompares++; $display("FAIL reset_outs: got %h expected 0", outs);
        end
        vectors++;
    endtask

    task automatic test_entry;
        press(5'd1);
        if ({num1_bcd, num1_len, state} !== {12'h001, 3'd1, 3'd1}) begin
            miscompares++; $display("FAIL entry_first: got %h/%0d/%0d expected 001/1/1", num1_bcd, num1_len, state);
        end
        vectors++;
        press(5'd2); press(5'd3); press(5'd4);
        if ({num1_bcd, num1_len, state} !== {12'h123, 3'd3, 3'd1}) begin
            miscompares++; $display("FAIL entry_overflow: got %h/%0d/%0d expected 123/3/1", num1_bcd, num1_len, state);
        end
        vectors++;
    endtask

    task automatic test_exec;
        int starts;
        press(5'd15);
        press(5'd11);
        if ({num1_neg, num1_len, state} !== {1'b1, 3'd0, 3'd1}) begin
            miscompares++; $display("FAIL exec_sign: got %b/%0d/%0d expected 1/0/1", num1_neg, num1_len, state);
        end
        vectors++;
        press(5'd7); press(5'd12);
        if ({op_code, op_valid, state} !== {2'b10, 1'b1, 3'd2}) begin
            miscompares++; $display("FAIL exec_op: got %b/%b/%0d expected 10/1/2", op_code, op_valid, state);
        end
        vectors++;
        press(5'd5); press(5'd14);
        if ({state, alu_start} !== {3'd3, 1'b1}) begin
            miscompares++; $display("FAIL exec_enter: got state %0d start %b expected 3/1", state, alu_start);
        end
        vectors++;
        starts = int'(alu_start);
        repeat (8) begin
            @(negedge clk1kHz);
            starts += int'(alu_start);
        end
        press(5'd3);
        starts += int'(alu_start);
        if ({num2_bcd, num2_len, state} !== {12'h005, 3'd1, 3'd3}) begin
            miscompares++; $display("FAIL exec_key_ignored: got %h/%0d/%0d expected 005/1/3", num2_bcd, num2_len, state);
        end
        vectors++;
        pulse_done(1'b0);
        if (starts !== 1) begin
            miscompares++; $display("FAIL exec_start_width: got %0d cycles expected 1", starts);
        end
        vectors++;
        if ({state, err, num1_bcd, num1_neg, op_code, num2_bcd} !== {3'd4, 1'b0, 12'h007, 1'b1, 2'b10, 12'h005}) begin
            miscompares++; $display("FAIL exec_done: got state %0d err %b n1 %h neg %b op %b n2 %h expected 4/0/007/1/10/005",
                                    state, err, num1_bcd, num1_neg, op_code, num2_bcd);
        end
        vectors++;
    endtask

    task automatic test_backspace;
        press(5'd4);
        if ({num1_bcd, num1_len, num1_neg, op_valid, num2_len, state} !== {12'h004, 3'd1, 1'b0, 1'b0, 3'd0, 3'd1}) begin
            miscompares++; $display("FAIL bksp_restart: got %h/%0d/%b/%b/%0d/%0d expected 004/1/0/0/0/1",
                                    num1_bcd, num1_len, num1_neg, op_valid, num2_len, state);
        end
        vectors++;
        press(5'd10); press(5'd9);
        if ({op_code, num2_bcd, num2_len, state} !== {2'b00, 12'h009, 3'd1, 3'd2}) begin
            miscompares++; $display("FAIL bksp_setup: got %b/%h/%0d/%0d expected 00/009/1/2", op_code, num2_bcd, num2_len, state);
        end
        vectors++;
        press(5'd16);
        press(5'd14);
        press(5'd12);
        if ({num2_bcd, num2_len, op_code, state} !== {12'h000, 3'd0, 2'b00, 3'd2}) begin
            miscompares++; $display("FAIL bksp_num2_empty: got %h/%0d/%b/%0d expected 000/0/00/2", num2_bcd, num2_len, op_code, state);
        end
        vectors++;
        press(5'd16);
        if ({op_valid, num1_len, state} !== {1'b0, 3'd1, 3'd1}) begin
            miscompares++; $display("FAIL bksp_op_drop: got %b/%0d/%0d expected 0/1/1", op_valid, num1_len, state);
        end
        vectors++;
        press(5'd16);
        press(5'd10);
        if ({num1_bcd, num1_len, op_valid, state} !== {12'h000, 3'd0, 1'b0, 3'd1}) begin
            miscompares++; $display("FAIL bksp_num1_empty: got %h/%0d/%b/%0d expected 000/0/0/1", num1_bcd, num1_len, op_valid, state);
        end
        vectors++;
        press(5'd16);
        if (state !== 3'd0) begin
            miscompares++; $display("FAIL bksp_to_sign: got %0d expected 0", state);
        end
        vectors++;
    endtask

    task automatic test_timeout;
        press(5'd15);
        press(5'd8); press(5'd13); press(5'd2); press(5'd14);
        for (int i = 1; i < TMO; i++) @(negedge clk1kHz);
        if ({state, err} !== {3'd3, 1'b0}) begin
            miscompares++; $display("FAIL tmo_early: got %0d/%b expected 3/0", state, err);
        end
        vectors++;
        @(negedge clk1kHz);
        if ({state, err} !== {3'd5, 1'b1}) begin
            miscompares++; $display("FAIL tmo_err: got %0d/%b expected 5/1", state, err);
        end
        vectors++;
        press(5'd5);
        if ({state, err, num2_bcd} !== {3'd5, 1'b1, 12'h002}) begin
            miscompares++; $display("FAIL tmo_err_hold: got %0d/%b/%h expected 5/1/002", state, err, num2_bcd);
        end
        vectors++;
        press(5'd15);
        if (outs !== 39'd0) begin
            miscompares++; $display("FAIL tmo_clear: got %h expected 0", outs);
        end
        vectors++;
    endtask

    task automatic test_clear_race;
        press(5'd1); press(5'd10); press(5'd1); press(5'd14);
        key_valid = 1'b1;
        key_code  = 5'd15;
        alu_done  = 1'b1;
        @(negedge clk1kHz);
        key_valid = 1'b0;
        key_code  = '0;
        alu_done  = 1'b0;
        if (outs !== 39'd0) begin
            miscompares++; $display("FAIL race_clear_wins: got %h expected 0", outs);
        end
        vectors++;
        pulse_done(1'b0);
        if (outs !== 39'd0) begin
            miscompares++; $display("FAIL race_late_done: got %h expected 0", outs);
        end
        vectors++;
        press(5'd1); press(5'd10); press(5'd1); press(5'd14);
        pulse_done(1'b1);
        if ({state, err} !== {3'd5, 1'b1}) begin
            miscompares++; $display("FAIL race_alu_err: got %0d/%b expected 5/1", state, err);
        end
        vectors++;
        press(5'd15);
    endtask

    task automatic test_done_restart;
        press(5'd2); press(5'd12); press(5'd3); press(5'd14);
        pulse_done(1'b0);
        press(5'd6);
        if ({num1_bcd, num1_len, num1_neg, op_code, op_valid, num2_bcd, num2_len, state}
                !== {12'h006, 3'd1, 1'b0, 2'b00, 1'b0, 12'h000, 3'd0, 3'd1}) begin
            miscompares++; $display("FAIL done_digit: got n1 %h/%0d neg %b op %b/%b n2 %h/%0d st %0d expected 006/1 0 00/0 000/0 1",
                                    num1_bcd, num1_len, num1_neg, op_code, op_valid, num2_bcd, num2_len, state);
        end
        vectors++;
        press(5'd20);
        press(5'd10); press(5'd7);
        if ({num1_bcd, num1_len, op_valid, num2_bcd, state} !== {12'h006, 3'd1, 1'b1, 12'h007, 3'd2}) begin
            miscompares++; $display("FAIL done_ignored_code: got %h/%0d/%b/%h/%0d expected 006/1/1/007/2",
                                    num1_bcd, num1_len, op_valid, num2_bcd, state);
        end
        vectors++;
        rst = 1'b1;
        @(negedge clk1kHz);
        rst = 1'b0;
        if (outs !== 39'd0) begin
            miscompares++; $display("FAIL rst_mid_num2: got %h expected 0", outs);
        end
        vectors++;
        press(5'd2); press(5'd12); press(5'd3); press(5'd14);
        pulse_done(1'b0);
        press(5'd11);
        if ({num1_bcd, num1_len, num1_neg, op_valid, num2_len, state} !== {12'h000, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1}) begin
            miscompares++; $display("FAIL done_minus: got %h/%0d/%b/%b/%0d/%0d expected 000/0/1/0/0/1",
                                    num1_bcd, num1_len, num1_neg, op_valid, num2_len, state);
        end
        vectors++;
    endtask

    initial begin
        @(negedge clk1kHz);
        test_reset;
        test_entry;
        test_exec;
        test_backspace;
        test_timeout;
        test_clear_race;
        test_done_restart;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
